shift_reg_piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter; the sending end of our serial shift chains.
//   - Accepts a WIDTH-bit word through a valid/ready handshake.
//   - Drives the word out one bit per accepted shift, with a per-bit valid and a last-bit marker.
//   - Feeds SISO stages or serial links. The downstream consumer paces it through shift_en.

---
 rtl/shift_reg_piso_tx_if.sv | 25 ++
 rtl/shift_reg_piso_tx.sv | 166 ++++++++++++++++
 tb/tb_shift_reg_piso_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_piso_tx_if.sv
// Handshake and serial-stream bundle for the PISO transmitter.
// master: the side that offers words and paces the shifting.
// slave : the transmitter itself.
interface shift_reg_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and presents it one
// bit per shift_en edge, with a per-bit valid and a last-bit marker.
// Optional feature macro: SHIFT_PARITY_EN appends an even-parity bit after
// the payload and moves ser_last onto it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a word, load_ready=1, serial outputs at rest
// ST_SHIFT  | presenting payload bit bit_cnt, advances on shift_en
// ST_PARITY | presenting the parity bit (SHIFT_PARITY_EN builds only)
module shift_reg_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_reg_piso_tx_if.slave   tx
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_rot;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic             r_ser_out;
    logic             w_ser_out_nxt;
    logic             r_ser_valid;
    logic             w_ser_valid_nxt;
    logic             r_ser_last;
    logic             w_ser_last_nxt;
    logic             r_load_ready;
    logic             w_load_ready_nxt;
    logic [WIDTH-1:0] w_load_data;
    logic             w_load_head;
    logic             w_rot_head;

    assign w_load_data = tx.load_data;

    // The word is rotated rather than shifted so the full captured word
    // (and therefore its parity) survives until the end of the frame.
    always_comb begin
        if (MSB_FIRST) begin
            w_shift_rot = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
        end else begin
            w_shift_rot = {r_shift[0], r_shift[WIDTH-1:1]};
        end
    end

    assign w_load_head = MSB_FIRST ? w_load_data[WIDTH-1] : w_load_data[0];
    assign w_rot_head  = MSB_FIRST ? w_shift_rot[WIDTH-1] : w_shift_rot[0];

    // State and output registers; rst aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_ser_out    <= 1'b0;
            r_ser_valid  <= 1'b0;
            r_ser_last   <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_ser_out    <= w_ser_out_nxt;
            r_ser_valid  <= w_ser_valid_nxt;
            r_ser_last   <= w_ser_last_nxt;
            r_load_ready <= w_load_ready_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_ser_out_nxt    = r_ser_out;
        w_ser_valid_nxt  = r_ser_valid;
        w_ser_last_nxt   = r_ser_last;
        w_load_ready_nxt = r_load_ready;

        case (r_state)
            ST_IDLE: begin
                w_ser_out_nxt    = 1'b0;
                w_ser_valid_nxt  = 1'b0;
                w_ser_last_nxt   = 1'b0;
                w_load_ready_nxt = 1'b1;
                if (tx.load_valid) begin
                    w_state_nxt      = ST_SHIFT;
                    w_shift_nxt      = w_load_data;
                    w_bit_cnt_nxt    = '0;
                    w_ser_out_nxt    = w_load_head;
                    w_ser_valid_nxt  = 1'b1;
                    w_ser_last_nxt   = 1'b0;
                    w_load_ready_nxt = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (tx.shift_en) begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_IDX) begin
`ifdef SHIFT_PARITY_EN
                        w_state_nxt    = ST_PARITY;
                        w_ser_out_nxt  = ^r_shift;
                        w_ser_last_nxt = 1'b1;
`else
                        w_state_nxt      = ST_IDLE;
                        w_ser_out_nxt    = 1'b0;
                        w_ser_valid_nxt  = 1'b0;
                        w_ser_last_nxt   = 1'b0;
                        w_load_ready_nxt = 1'b1;
`endif
                    end else begin
                        w_shift_nxt   = w_shift_rot;
                        w_ser_out_nxt = w_rot_head;
`ifdef SHIFT_PARITY_EN
                        w_ser_last_nxt = 1'b0;
`else
                        w_ser_last_nxt = ((r_bit_cnt + CNT_W'(1)) == LAST_IDX);
`endif
                    end
                end
            end

`ifdef SHIFT_PARITY_EN
            ST_PARITY: begin
                if (tx.shift_en) begin
                    w_state_nxt      = ST_IDLE;
                    w_ser_out_nxt    = 1'b0;
                    w_ser_valid_nxt  = 1'b0;
                    w_ser_last_nxt   = 1'b0;
                    w_load_ready_nxt = 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt      = ST_IDLE;
                w_ser_out_nxt    = 1'b0;
                w_ser_valid_nxt  = 1'b0;
                w_ser_last_nxt   = 1'b0;
                w_load_ready_nxt = 1'b1;
            end
        endcase
    end

    assign tx.load_ready = r_load_ready;
    assign tx.ser_out    = r_ser_out;
    assign tx.ser_valid  = r_ser_valid;
    assign tx.ser_last   = r_ser_last;
    assign tx.busy       = r_ser_valid;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
`timescale 1ns/1ps
module tb_shift_reg_piso_tx;
    localparam int WIDTH     = 4;
    localparam bit MSB_FIRST = 1'b1;
`ifdef SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_reg_piso_tx_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk (clk),
        .rst (rst),
        .tx  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a list of bits plus a read position.
    logic m_frame[$];
    int   m_pos    = 0;
    bit   m_active = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_frame.delete();
        end else if (!m_active) begin
            if (bus.load_valid === 1'b1) begin
                m_frame.delete();
                for (int i = 0; i < WIDTH; i++)
                    m_frame.push_back(MSB_FIRST ? bus.load_data[WIDTH-1-i] : bus.load_data[i]);
`ifdef SHIFT_PARITY_EN
                m_frame.push_back(^bus.load_data);
`endif
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (bus.shift_en === 1'b1) begin
            m_pos++;
            if (m_pos == m_frame.size()) m_active = 1'b0;
        end
    end

    // Observed stream: bits the consumer actually takes.
    logic s_bits[$];
    logic s_last[$];

    // Per-cycle comparison, sampled between the input update and the next edge.
    always begin
        logic e_out, e_last;
        @(negedge clk);
        #3;
        e_out  = m_active ? m_frame[m_pos] : 1'b0;
        e_last = m_active && (m_pos == m_frame.size() - 1);
        check("ser_valid",  bus.ser_valid,  m_active);
        check("busy",       bus.busy,       m_active);
        check("load_ready", bus.load_ready, !m_active);
        check("ser_out",    bus.ser_out,    e_out);
        check("ser_last",   bus.ser_last,   e_last);
        if (!rst && bus.ser_valid === 1'b1 && bus.shift_en === 1'b1) begin
            s_bits.push_back(bus.ser_out);
            s_last.push_back(bus.ser_last);
        end
    end

    task automatic step(input logic lv, input logic [WIDTH-1:0] ld, input logic se);
        @(negedge clk);
        #1;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.shift_en   = se;
    endtask

    task automatic clear_stream();
        s_bits.delete();
        s_last.delete();
    endtask

    task automatic check_stream(input string name, input logic got[$], input logic exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_bit%0d", name, i), got[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e[$];
        logic el[$];
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.shift_en   = 1'b0;

        // 1: reset values
        repeat (2) @(negedge clk);
        #2;
        check("rst_ready", bus.load_ready, 1'b1);
        check("rst_valid", bus.ser_valid, 1'b0);
        check("rst_last",  bus.ser_last, 1'b0);
        check("rst_out",   bus.ser_out, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0, 1'b0);

        // 2: 1011 with shift_en held high
        clear_stream();
        step(1'b1, 4'b1011, 1'b0);
        repeat (NBITS) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        #2;
        check("t2_ready_back", bus.load_ready, 1'b1);
        e  = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SHIFT_PARITY_EN
        e.push_back(1'b1);
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
        check_stream("t2_bits", s_bits, e);
        check_stream("t2_last", s_last, el);

        // 3: 0110 with shift_en paced 1,0,0,1,1,1; then shift_en in idle
        clear_stream();
        step(1'b1, 4'b0110, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
`ifdef SHIFT_PARITY_EN
        step(1'b0, '0, 1'b1);
`endif
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        e = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef SHIFT_PARITY_EN
        e.push_back(1'b0);
`endif
        check_stream("t3_bits", s_bits, e);

        // 4: load_valid held with 1111 during a 1001 frame
        clear_stream();
        step(1'b1, 4'b1001, 1'b0);
        repeat (NBITS) step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b0);
        e = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef SHIFT_PARITY_EN
        e.push_back(1'b0);
`endif
        check_stream("t4_first", s_bits, e);
        clear_stream();
        repeat (NBITS) step(1'b0, 4'b0000, 1'b1);
        step(1'b0, '0, 1'b0);
        e = '{1'b1, 1'b1, 1'b1, 1'b1};
`ifdef SHIFT_PARITY_EN
        e.push_back(1'b0);
`endif
        check_stream("t4_second", s_bits, e);

        // 5: reset after two bits of 1100, then a clean 0011 frame
        clear_stream();
        step(1'b1, 4'b1100, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("t5_abort_valid", bus.ser_valid, 1'b0);
        check("t5_abort_ready", bus.load_ready, 1'b1);
        check("t5_abort_out",   bus.ser_out, 1'b0);
        e = '{1'b1, 1'b1};
        check_stream("t5_partial", s_bits, e);
        @(negedge clk);
        #1;
        rst = 1'b0;
        clear_stream();
        step(1'b1, 4'b0011, 1'b0);
        repeat (NBITS) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        e = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SHIFT_PARITY_EN
        e.push_back(1'b0);
`endif
        check_stream("t5_after", s_bits, e);

        // Randomized traffic, checked every cycle against the model.
        repeat (600) begin
            step(logic'($urandom_range(0, 3) == 0), WIDTH'($urandom), logic'($urandom_range(0, 1)));
        end
        begin
            int budget;
            budget = 0;
            while (bus.load_ready !== 1'b1 && budget < 20) begin
                step(1'b0, '0, 1'b1);
                #2;
                budget++;
            end
            check("drain_ready", bus.load_ready, 1'b1);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
